// File: rtl/rng_word_server.sv
// Buffers one keystream block and serves it LSB-first as a stream of words.
// Each served slot is shifted out and zero-filled so no word is ever served twice.
module rng_word_server #(
  parameter int BLOCK_WIDTH = 512,
  parameter int WORD_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic                                     clear,
  input  logic [BLOCK_WIDTH-1:0]                   block_in,
  input  logic                                     block_valid,
  output logic                                     block_ready,
  output logic [WORD_WIDTH-1:0]                    word_out,
  output logic                                     word_valid,
  input  logic                                     word_ready,
  output logic [$clog2(BLOCK_WIDTH/WORD_WIDTH):0]  words_left,
  output logic [COUNT_WIDTH-1:0]                   blocks_served
);

  localparam int NUM_WORDS  = BLOCK_WIDTH / WORD_WIDTH;
  localparam int LEFT_WIDTH = $clog2(NUM_WORDS) + 1;

  typedef enum logic {
    EMPTY   = 1'b0,
    SERVING = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [BLOCK_WIDTH-1:0]  r_buffer;
  logic [LEFT_WIDTH-1:0]   r_words_left;
  logic [COUNT_WIDTH-1:0]  r_blocks_served;
  logic                    w_block_accept;
  logic                    w_word_accept;
  logic                    w_last_word;

  always_comb begin
    w_next_state   = r_state;
    w_block_accept = 1'b0;
    w_word_accept  = 1'b0;
    w_last_word    = 1'b0;
    block_ready    = 1'b0;
    word_valid     = 1'b0;
    case (r_state)
      EMPTY: begin
        block_ready    = !clear;
        w_block_accept = block_valid;
        if (block_valid) w_next_state = SERVING;
      end
      SERVING: begin
        word_valid    = 1'b1;
        w_word_accept = word_ready;
        w_last_word   = word_ready && (r_words_left == LEFT_WIDTH'(1));
        if (w_last_word) w_next_state = EMPTY;
      end
      default: w_next_state = EMPTY;
    endcase
    // Clear wins over any handshake in the same cycle.
    if (clear) begin
      w_next_state   = EMPTY;
      w_block_accept = 1'b0;
      w_word_accept  = 1'b0;
      w_last_word    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= EMPTY;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_buffer        <= '0;
      r_words_left    <= '0;
      r_blocks_served <= '0;
    end else if (clear) begin
      r_buffer        <= '0;
      r_words_left    <= '0;
      r_blocks_served <= '0;
    end else if (w_block_accept) begin
      r_buffer     <= block_in;
      r_words_left <= LEFT_WIDTH'(NUM_WORDS);
    end else if (w_word_accept) begin
      r_buffer     <= r_buffer >> WORD_WIDTH;
      r_words_left <= r_words_left - LEFT_WIDTH'(1);
      if (w_last_word) r_blocks_served <= r_blocks_served + COUNT_WIDTH'(1);
    end
  end

  assign word_out      = r_buffer[WORD_WIDTH-1:0];
  assign words_left    = r_words_left;
  assign blocks_served = r_blocks_served;

endmodule

// File: tb/tb_rng_word_server.sv
// Bench for rng_word_server: a queue-based model of the word stream checked every cycle,
// plus literal expectations for reset, an ordered drain, clear, async reset and counter wrap.
module tb_rng_word_server;

  localparam int BW = 512;
  localparam int WW = 32;
  localparam int CW = 8;
  localparam int NW = BW / WW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear;
  logic [BW-1:0] block_in;
  logic          block_valid;
  logic          block_ready;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          word_ready;
  logic [4:0]    words_left;
  logic [CW-1:0] blocks_served;

  rng_word_server #(.BLOCK_WIDTH(BW), .WORD_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .block_in(block_in), .block_valid(block_valid), .block_ready(block_ready),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .words_left(words_left), .blocks_served(blocks_served)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: words still owed to the consumer, in serving order.
  logic [WW-1:0] m_q[$];
  int            m_served  = 0;
  bit            m_wrapped = 1'b0;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n || clear) begin
      m_q.delete();
      m_served = 0;
    end else if (m_q.size() == 0) begin
      if (block_valid)
        for (int k = 0; k < NW; k++) m_q.push_back(block_in[k*WW +: WW]);
    end else if (word_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_served = (m_served + 1) % (1 << CW);
        if (m_served == 0) m_wrapped = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [WW-1:0] exp_word;
    exp_word = (m_q.size() > 0) ? m_q[0] : '0;
    chk("word_valid", 32'(word_valid), 32'(m_q.size() > 0));
    chk("word_out", word_out, exp_word);
    chk("block_ready", 32'(block_ready), 32'((m_q.size() == 0) && !clear));
    chk("words_left", 32'(words_left), 32'(m_q.size()));
    chk("blocks_served", 32'(blocks_served), 32'(m_served));
  endtask

  initial forever begin
    @(negedge clock);
    compare_all();
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_block();
    for (int k = 0; k < NW; k++) block_in[k*WW +: WW] = $urandom();
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; clear = 1'b0; block_valid = 1'b0; word_ready = 1'b0; block_in = '0;
    repeat (3) step();
    chk("rst_block_ready", 32'(block_ready), 32'd1);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_out", word_out, 32'd0);
    reset_n = 1'b1;
    step();
    chk("idle_words_left", 32'(words_left), 32'd0);
    chk("idle_blocks_served", 32'(blocks_served), 32'd0);

    // Ordered drain: word k = k, consumer always ready.
    for (int k = 0; k < NW; k++) block_in[k*WW +: WW] = WW'(k);
    block_valid = 1'b1; word_ready = 1'b1;
    step();
    block_valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      chk("drain_valid", 32'(word_valid), 32'd1);
      chk("drain_word", word_out, 32'(k));
      chk("drain_left", 32'(words_left), 32'(NW - k));
      step();
    end
    chk("drain_done_ready", 32'(block_ready), 32'd1);
    chk("drain_done_left", 32'(words_left), 32'd0);
    chk("drain_done_served", 32'(blocks_served), 32'd1);

    // Backpressure 1,0,0,1 with block_valid held and block_in changing mid-drain.
    cyc = 0;
    block_valid = 1'b1;
    while (m_served < 3 && cyc < 300) begin
      rand_block();
      word_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      step();
      cyc++;
    end
    chk("backpressure_timeout", 32'(m_served >= 3), 32'd1);
    block_valid = 1'b0;
    while (word_valid && cyc < 400) begin word_ready = 1'b1; step(); cyc++; end

    // Clear after five accepted words.
    rand_block(); block_valid = 1'b1; word_ready = 1'b1;
    step();
    block_valid = 1'b0;
    repeat (5) step();
    chk("pre_clear_left", 32'(words_left), 32'(NW - 5));
    clear = 1'b1;
    #1 chk("clear_block_ready", 32'(block_ready), 32'd0);
    step();
    clear = 1'b0;
    #1;
    chk("clear_word_valid", 32'(word_valid), 32'd0);
    chk("clear_words_left", 32'(words_left), 32'd0);
    chk("clear_served", 32'(blocks_served), 32'd0);
    chk("clear_block_ready_after", 32'(block_ready), 32'd1);

    // Asynchronous reset between edges mid-block.
    rand_block(); block_valid = 1'b1;
    step();
    block_valid = 1'b0;
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_word_valid", 32'(word_valid), 32'd0);
    chk("arst_word_out", word_out, 32'd0);
    chk("arst_words_left", 32'(words_left), 32'd0);
    chk("arst_block_ready", 32'(block_ready), 32'd1);
    compare_all();
    step();
    reset_n = 1'b1;
    step();

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      rand_block();
      block_valid = ($urandom_range(0, 2) != 0);
      word_ready  = ($urandom_range(0, 3) != 0);
      clear       = ($urandom_range(0, 59) == 0);
      step();
    end
    clear = 1'b0;

    // Drain until the served counter wraps.
    m_wrapped = 1'b0;
    block_valid = 1'b1; word_ready = 1'b1;
    cyc = 0;
    while (!m_wrapped && cyc < 6000) begin
      if (block_ready) rand_block();
      step();
      cyc++;
    end
    block_valid = 1'b0;
    chk("wrap_reached", 32'(m_wrapped), 32'd1);
    #1 chk("wrap_served_zero", 32'(blocks_served), 32'd0);
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rng_word_server.md
Name: rng_word_server

Overview:
- Responder/buffer that accepts 512-bit keystream blocks from the chacha20_rng core over a valid/ready interface.
- Hands the block out as a stream of WORD_WIDTH-bit words to a downstream consumer, one word per accepted handshake.
- Guarantees that no word is ever served twice: each consumed slot is shifted out and zero-filled.
- Sits between chacha20_rng and consumers such as LED or UART demos, replacing free-running sampling of the RNG output.

Parameters:
- BLOCK_WIDTH, 512, width of an input keystream block.
- WORD_WIDTH, 32, width of an output word; BLOCK_WIDTH must be a multiple of it.
- NUM_WORDS, BLOCK_WIDTH/WORD_WIDTH (16), derived; not overridable.
- COUNT_WIDTH, 16, width of the blocks_served counter.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; same effect as reset, applied on a clock edge.
- block_in  in  BLOCK_WIDTH  keystream block from chacha20_rng.
- block_valid  in  1  block_in is valid.
- block_ready  out  1  server will accept a block this cycle.
- word_out  out  WORD_WIDTH  current word.
- word_valid  out  1  word_out is valid.
- word_ready  in  1  consumer accepts word_out this cycle.
- words_left  out  $clog2(NUM_WORDS)+1  unconsumed words in the buffer (0..16).
- blocks_served  out  COUNT_WIDTH  number of blocks fully drained; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=EMPTY; buffer=0; words_left=0; blocks_served=0.
  - Outputs during reset: word_valid=0, word_out=0, block_ready=1.
  - block_valid is ignored while reset_n is low.
- Clear (synchronous): clear high on an edge gives the same result as reset and overrides every handshake in that cycle. block_ready is forced to 0 in any cycle where clear=1.
- States:
  - EMPTY: block_ready=1, word_valid=0.
  - SERVING: block_ready=0, word_valid=1.
- All outputs decode combinationally from registered state. word_out = buffer[WORD_WIDTH-1:0].
- Block accept (EMPTY and block_valid=1):
  - Next edge: buffer<=block_in; words_left<=NUM_WORDS; state<=SERVING.
  - First word is visible the cycle after acceptance, i.e. 1-cycle latency.
- Word accept (SERVING and word_ready=1):
  - buffer <= buffer >> WORD_WIDTH, zero-filled from the MSB.
  - words_left decrements by 1.
  - Word order is LSB first: word k = block_in[k*WORD_WIDTH +: WORD_WIDTH].
- Last word (word accept with words_left=1):
  - Next edge: state<=EMPTY; words_left<=0; buffer is all zero.
  - blocks_served increments by 1, wrapping 0xFFFF -> 0x0000.
- Handshake rules:
  - word_ready while word_valid=0 has no effect.
  - block_valid while block_ready=0 has no effect.
  - No prefetch: a new block is requested only after the last word is accepted.
  - Peak throughput: NUM_WORDS words per NUM_WORDS+1 cycles.
- Stability: word_out and word_valid hold stable while word_valid=1 and word_ready=0, for any duration.
- No simultaneous events: block and word handshakes are mutually exclusive by state.
- Reset mid-block: the remaining words are discarded; the next word served comes from a fresh block.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles, release -> block_ready=1, word_valid=0, words_left=0, blocks_served=0.
- Single block drain, word_ready held 1:
  - Stimulus: block_in = concat of words 0x0000000F..0x00000000 (word k = k) with block_valid=1 for one cycle.
  - Response: 1 cycle later word_valid=1, word_out=0; then 0,1,...,15 on 16 consecutive cycles.
  - After the last word: block_ready=1, words_left=0, blocks_served=1.
- Backpressure:
  - Stimulus: word_ready toggles 1,0,0,1 during a block.
  - Response: word_out holds the same value while word_ready=0; words_left decrements only on accept cycles; total accepted words=16, no duplicates.
- Block ignored while serving: block_valid=1 held continuously with a different block_in mid-drain -> buffer unchanged; the next block is accepted only in the cycle after word 15 is accepted.
- Clear/reset mid-block:
  - Stimulus: after 5 words accepted, assert clear for one cycle.
  - Response: word_valid=0, words_left=0, blocks_served unchanged from reset (0), block_ready=1 the following cycle.
  - Repeat with reset_n pulsed low asynchronously between edges: outputs go to reset values immediately.
- Counter wrap: drain 65536 blocks (or preload the counter via force to 0xFFFF) -> blocks_served reads 0x0000 after the next drained block.
